uart_rx_engine: RTL

Parametrised UART receive engine for the VGA project's serial command path. It runs on the 16x-baud clock and takes the raw `rx` line through a synchroniser, then validates the start bit. Each bit is recovered by 3-sample majority vote, and the engine delivers 5–9 data bits per frame with parity and framing status. Frame format is run-time configurable through the 4-bit address/data config port that the command decoder already drives.

---
 rtl/uart_rx_engine.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
`timescale 1ns/1ps
// uart_rx_engine: oversampled UART receiver. Synchronises rx, validates the
// start bit, recovers each bit by 3-sample majority vote around mid-bit and
// reports 5..MAX_BITS data bits per frame with parity/framing status.
module uart_rx_engine #(
    parameter int OVERSAMPLE  = 16,
    parameter int MAX_BITS    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_16bd,
    input  logic                rst,
    input  logic                rx,
    input  logic                cfg_valid,
    input  logic [3:0]          cfg_addr,
    input  logic [3:0]          cfg_data,
    output logic                cfg_ack,
    output logic [MAX_BITS-1:0] frame,
    output logic                frame_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy
);
    localparam int M       = OVERSAMPLE / 2;
    localparam int CW      = $clog2(OVERSAMPLE);
    localparam int LW      = $clog2(MAX_BITS + 1);
    localparam int LEN_RST = (MAX_BITS < 8) ? MAX_BITS : 8;
    localparam logic [CW-1:0] C_LO  = CW'(M - 1);
    localparam logic [CW-1:0] C_MID = CW'(M);
    localparam logic [CW-1:0] C_HI  = CW'(M + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [CW-1:0]          cnt;
    logic [LW-1:0]          idx;
    logic                   stop_idx;
    logic                   s_lo, s_mid;
    logic [MAX_BITS-1:0]    frame_nxt;
    logic                   perr, ferr;

    // live config registers and the copy frozen for the frame in flight
    logic          par_en_r, par_odd_r, stop2_r;
    logic [LW-1:0] len_r;
    logic          par_en_l, par_odd_l, stop2_l;
    logic [LW-1:0] len_l;
    logic          par_en_w, par_odd_w, stop2_w;
    logic [LW-1:0] len_w;
    logic          cfg_we;
    int            len_calc;

    logic vote, at_vote, at_wrap, last_bit, last_stop, start_det, frame_done;

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign busy = (state != S_IDLE);

    // rx synchroniser; flops reset high so reset never looks like a start bit
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    // config write decode; the written value is visible combinationally so a
    // frame starting in the same cycle latches the new setting
    always_comb begin
        cfg_we    = cfg_valid && (state == S_IDLE) && !cfg_ack;
        par_en_w  = par_en_r;
        par_odd_w = par_odd_r;
        stop2_w   = stop2_r;
        len_w     = len_r;
        len_calc  = 5 + int'(cfg_data[2:0]);
        if (len_calc > MAX_BITS) len_calc = MAX_BITS;
        if (cfg_we) begin
            case (cfg_addr)
                4'h9:    par_en_w  = cfg_data[3];
                4'hA:    par_odd_w = cfg_data[3];
                4'hB:    stop2_w   = cfg_data[3];
                4'hC:    len_w     = LW'(len_calc);
                default: ;
            endcase
        end
    end

    // config registers and write acknowledge
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            stop2_r   <= 1'b0;
            len_r     <= LW'(LEN_RST);
            cfg_ack   <= 1'b0;
        end else begin
            par_en_r  <= par_en_w;
            par_odd_r <= par_odd_w;
            stop2_r   <= stop2_w;
            len_r     <= len_w;
            cfg_ack   <= cfg_we;
        end
    end

    // state register
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // next state, majority vote and sample-point strobes
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        vote       = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
        at_vote    = (cnt == C_HI);
        at_wrap    = (cnt == C_END);
        last_bit   = (idx == len_l - LW'(1));
        last_stop  = (stop_idx == stop2_l);
        start_det  = (state == S_IDLE) && !rxs;
        case (state)
            S_IDLE:      if (!rxs) state_nxt = S_START;
            S_START: begin
                if (at_vote && vote) state_nxt = S_IDLE;
                else if (at_wrap)    state_nxt = S_DATA;
            end
            S_DATA:      if (at_wrap && last_bit) state_nxt = par_en_l ? S_PARITY : S_STOP;
            S_PARITY:    if (at_wrap) state_nxt = S_STOP;
            S_STOP: begin
                if (at_vote && last_stop) begin
                    frame_done = 1'b1;
                    state_nxt  = (ferr || !vote) ? S_WAIT_HIGH : S_IDLE;
                end
            end
            S_WAIT_HIGH: if (rxs) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // bit timing, sample capture, data accumulation and error tracking
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            idx       <= '0;
            stop_idx  <= 1'b0;
            s_lo      <= 1'b1;
            s_mid     <= 1'b1;
            frame_nxt <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            par_en_l  <= 1'b0;
            par_odd_l <= 1'b0;
            stop2_l   <= 1'b0;
            len_l     <= LW'(LEN_RST);
        end else begin
            // detect cycle is sample 0 of the start bit
            cnt <= (state == S_IDLE) ? CW'(1) : (at_wrap ? '0 : cnt + CW'(1));
            if (cnt == C_LO)  s_lo  <= rxs;
            if (cnt == C_MID) s_mid <= rxs;
            if (start_det) begin
                frame_nxt <= '0;
                idx       <= '0;
                stop_idx  <= 1'b0;
                perr      <= 1'b0;
                ferr      <= 1'b0;
                par_en_l  <= par_en_w;
                par_odd_l <= par_odd_w;
                stop2_l   <= stop2_w;
                len_l     <= len_w;
            end
            if (state == S_DATA) begin
                if (at_vote) frame_nxt[idx] <= vote;
                if (at_wrap) idx <= idx + LW'(1);
            end
            if (state == S_PARITY && at_vote)
                perr <= (vote != ((^frame_nxt) ^ par_odd_l));
            if (state == S_STOP) begin
                if (at_vote && !vote) ferr <= 1'b1;
                if (at_wrap) stop_idx <= 1'b1;
            end
        end
    end

    // frame outputs update only with frame_valid and hold until the next one
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                frame      <= frame_nxt;
                parity_err <= perr;
                frame_err  <= ferr | ~vote;
            end
        end
    end
endmodule
